fetch_buffer: RTL

- Instruction-byte fetch stage sitting directly upstream-facing of the dual-port program ROM.
- Each issue cycle it drives PC and PC+1 onto the two ROM read ports and captures the two returned bytes one cycle later.
- Captured bytes are pushed, PC-tagged, into an internal byte FIFO; the decoder drains it one byte per valid/ready handshake.
- A redirect input (branch/jump/vector) flushes the FIFO and any in-flight read, then restarts fetch at a new PC.

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/byte_fifo_2w1r.sv | 75 +++++++
 rtl/fetch_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and helpers for the instruction-byte fetch stage.
package fetch_buffer_pkg;

    // Architectural PC width; tags in the byte FIFO carry the full PC.
    localparam int unsigned PC_W = 16;

    // Default PC loaded on reset.
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h8000;

    // FIFO entry is {byte, pc}.
    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + PC_W;
    endfunction

endpackage

// File: rtl/byte_fifo_2w1r.sv
// Byte FIFO taking zero or two pushes and zero or one pop per cycle.
module byte_fifo_2w1r #(
    parameter int unsigned Width = 24,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push2_i,
    input  logic [Width-1:0]           wdata0_i,
    input  logic [Width-1:0]           wdata1_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             pop_ok;

    // Pop of an empty FIFO is ignored.
    assign pop_ok = pop_i && (count_q != '0);

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push2_i) begin
                wr_ptr_d = wr_ptr_q + PtrW'(2);
                count_d  = count_d + CntW'(2);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                count_d  = count_d - CntW'(1);
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes two consecutive slots per push; no reset needed.
    always_ff @(posedge clk) begin
        if (push2_i && !flush_i) begin
            mem_q[wr_ptr_q]               <= wdata0_i;
            mem_q[wr_ptr_q + PtrW'(1)]    <= wdata1_i;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues PC/PC+1 to a dual-port ROM and queues tagged bytes.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 15,
    parameter int unsigned     DATA_W   = 8,
    parameter int unsigned     DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr1,
    output logic [ADDR_W-1:0] rom_addr2,
    input  logic [DATA_W-1:0] rom_data1,
    input  logic [DATA_W-1:0] rom_data2,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_byte,
    output logic [PC_W-1:0]   out_pc
);

    localparam int unsigned EntryW = entry_w(DATA_W);
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;
    localparam int unsigned CredW  = CntW + 2;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CntW-1:0]   count;
    logic [CredW-1:0]  need;
    logic              issue;
    logic              push2;
    logic              pop;
    logic [PC_W-1:0]   tag1;
    logic [EntryW-1:0] head;

    // (pc+1) mod 2^ADDR_W equals pc[ADDR_W-1:0]+1 truncated.
    assign rom_addr1 = pc_q[ADDR_W-1:0];
    assign rom_addr2 = rom_addr1 + ADDR_W'(1);

    // Issue only if both the in-flight pair and the new pair will fit.
    always_comb begin
        need  = CredW'(count) + (inflight_q ? CredW'(4) : CredW'(2));
        issue = !redirect && (need <= CredW'(DEPTH));
    end

    // PC / in-flight next state; redirect overrides everything.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + PC_W'(2);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign tag1  = inflight_pc_q + PC_W'(1);
    assign push2 = inflight_q && !redirect;
    assign pop   = out_valid && out_ready && !redirect;

    byte_fifo_2w1r #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (redirect),
        .push2_i  (push2),
        .wdata0_i ({rom_data1, inflight_pc_q}),
        .wdata1_i ({rom_data2, tag1}),
        .pop_i    (pop),
        .rdata_o  (head),
        .count_o  (count)
    );

    assign out_valid = (count != '0);
    assign out_byte  = head[EntryW-1:PC_W];
    assign out_pc    = head[PC_W-1:0];

endmodule
